// File: rtl/fp_div_seq_pkg.sv
// rtl/fp_div_seq_pkg.sv - shared types and constants for the sequential FP divider
// Purpose: default format widths, bias helper, FSM state encoding, special
//          exponent constants, rounding mode, classification and flag structs.
// Ports:   none (package).
package fp_div_seq_pkg;

  localparam int NEXP_DEF = 11;
  localparam int NMAN_DEF = 52;

  function automatic int bias_of(input int nexp);
    return (1 << (nexp - 1)) - 1;
  endfunction

  typedef enum logic [1:0] {IDLE, DIV, RND, DONE} state_t;

  // Sliced down to the instance exponent width where used.
  localparam logic [31:0] EXP_INF_ALL  = '1;
  localparam logic [31:0] EXP_QNAN_ALL = '1;

  typedef enum logic [1:0] {RNE, RTZ, RDN, RUP} rnd_mode_t;
  localparam rnd_mode_t RND_MODE = RNE;

  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
    logic sub;
    logic norm;
  } fp_cls_t;

  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
    logic norm;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fp_flags_t;

endpackage

// File: rtl/fp_div_seq_if.sv
// rtl/fp_div_seq_if.sv - operand/result handshake bundle of the FP divider
// Purpose: groups the input (a, b) and output (q, flags) valid/ready channels.
// Ports:   master drives in_valid/a/b/out_ready; slave drives in_ready,
//          out_valid, q and the nan/inf/zero/norm/dz/of/uf/nx flags.
interface fp_div_seq_if #(
  parameter int NEXP = 11,
  parameter int NMAN = 52
);
  localparam int W = NEXP + NMAN + 1;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] q;
  logic         nan;
  logic         inf;
  logic         zero;
  logic         norm;
  logic         dz;
  logic         of;
  logic         uf;
  logic         nx;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q, nan, inf, zero, norm, dz, of, uf, nx
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q, nan, inf, zero, norm, dz, of, uf, nx
  );

endinterface

// File: rtl/fp_class.sv
// rtl/fp_class.sv - IEEE-754 operand classifier
// Purpose: classifies an unsigned magnitude (exponent + fraction) as
//          nan/inf/zero/subnormal/normal.
// Ports:   xm  in  magnitude bits {exponent, fraction}
//          cls out one-hot class
module fp_class
  import fp_div_seq_pkg::*;
#(
  parameter int NEXP = NEXP_DEF,
  parameter int NMAN = NMAN_DEF
) (
  input  logic [NEXP+NMAN-1:0] xm,
  output fp_cls_t              cls
);

  logic [NEXP-1:0] e;
  logic [NMAN-1:0] f;

  assign e = xm[NEXP+NMAN-1:NMAN];
  assign f = xm[NMAN-1:0];

  always_comb begin
    cls      = '0;
    cls.nan  = (&e) & (|f);
    cls.inf  = (&e) & ~(|f);
    cls.zero = ~(|e) & ~(|f);
    cls.sub  = ~(|e) & (|f);
    cls.norm = (|e) & ~(&e);
  end

endmodule

// File: rtl/fp_div_iter.sv
// rtl/fp_div_iter.sv - restoring division iteration, one quotient bit per clock
// Purpose: holds remainder, divisor, quotient and bit counter; produces QBITS
//          quotient bits of ma/mb after a start pulse.
// Ports:   start  in  load ma/mb and begin (one cycle)
//          ma, mb in  mantissas with hidden bit
//          done   out high during the cycle that computes the last bit
//          quo    out quotient, MSB = integer bit
//          rem_nz out final remainder is non-zero (sticky)
module fp_div_iter #(
  parameter int NMAN  = 52,
  parameter int QBITS = NMAN + 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NMAN:0]    ma,
  input  logic [NMAN:0]    mb,
  output logic             done,
  output logic [QBITS-1:0] quo,
  output logic             rem_nz
);

  localparam int CW = $clog2(QBITS);
  localparam int RW = NMAN + 1;

  logic [NMAN+1:0] rem;
  logic [NMAN+1:0] rem_nx;
  logic [NMAN:0]   rem_sub;
  logic [NMAN:0]   mb_r;
  logic [CW-1:0]   cnt;
  logic            busy;
  logic            qbit;

  // rem < 2*mb always, so after a subtract the result fits in NMAN+1 bits
  // and the left shift cannot overflow the NMAN+2 bit register.
  always_comb begin
    qbit    = rem >= {1'b0, mb_r};
    rem_sub = RW'(rem - {1'b0, mb_r});
    rem_nx  = qbit ? {rem_sub, 1'b0} : {rem[NMAN:0], 1'b0};
  end

  assign done   = busy & (cnt == CW'(QBITS - 1));
  assign rem_nz = |rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem  <= '0;
      mb_r <= '0;
      quo  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      rem  <= {1'b0, ma};
      mb_r <= mb;
      quo  <= '0;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      rem <= rem_nx;
      quo <= {quo[QBITS-2:0], qbit};
      cnt <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/fp_div_seq.sv
// rtl/fp_div_seq.sv - iterative IEEE-754 divider q = a / b with valid/ready
// Purpose: flush-to-zero operand classification, special-case resolution,
//          restoring mantissa division, round-to-nearest-even packing.
// Ports:   clk    in  clock
//          rst_n  in  asynchronous active-low reset
//          io     slave side of fp_div_seq_if (in_valid/in_ready/a/b,
//                 out_valid/out_ready/q and class/exception flags)
module fp_div_seq
  import fp_div_seq_pkg::*;
#(
  parameter int NEXP  = NEXP_DEF,
  parameter int NMAN  = NMAN_DEF,
  parameter int BIAS  = bias_of(NEXP),
  parameter int QBITS = NMAN + 3
) (
  input  logic         clk,
  input  logic         rst_n,
  fp_div_seq_if.slave  io
);

  localparam int W  = NEXP + NMAN + 1;
  localparam int EW = NEXP + 2;
  localparam logic [NEXP-1:0]      EXP_INF  = EXP_INF_ALL[NEXP-1:0];
  localparam logic [NEXP-1:0]      EXP_QNAN = EXP_QNAN_ALL[NEXP-1:0];
  localparam logic signed [EW-1:0] E_BIAS   = EW'(BIAS);
  localparam logic signed [EW-1:0] E_MAX    = EW'((1 << NEXP) - 1);
  localparam logic signed [EW-1:0] E_ZERO   = '0;

  state_t state, state_nx;
  logic   accept, start, it_done, rem_nz;
  logic [QBITS-1:0] quo;

  // Subnormals become zero before classification.
  logic [W-2:0] mag_a, mag_b;
  fp_cls_t      ca, cb;

  assign mag_a = (io.a[W-2:NMAN] == '0) ? '0 : io.a[W-2:0];
  assign mag_b = (io.b[W-2:NMAN] == '0) ? '0 : io.b[W-2:0];

  fp_class #(.NEXP(NEXP), .NMAN(NMAN)) u_cls_a (.xm(mag_a), .cls(ca));
  fp_class #(.NEXP(NEXP), .NMAN(NMAN)) u_cls_b (.xm(mag_b), .cls(cb));

  fp_div_iter #(.NMAN(NMAN), .QBITS(QBITS)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .ma     ({1'b1, io.a[NMAN-1:0]}),
    .mb     ({1'b1, io.b[NMAN-1:0]}),
    .done   (it_done),
    .quo    (quo),
    .rem_nz (rem_nz)
  );

  // Special-case result, resolved at acceptance.
  logic         s_in, za, zb, sp_div;
  logic [W-1:0] sp_q;
  fp_flags_t    sp_f;

  always_comb begin
    s_in   = io.a[W-1] ^ io.b[W-1];
    za     = ca.zero | ca.sub;
    zb     = cb.zero | cb.sub;
    sp_div = 1'b0;
    sp_q   = '0;
    sp_f   = '0;
    if (ca.nan | cb.nan | (za & zb) | (ca.inf & cb.inf)) begin
      sp_q     = {1'b0, EXP_QNAN, 1'b1, {(NMAN-1){1'b0}}};
      sp_f.nan = 1'b1;
    end else if (ca.inf) begin
      sp_q     = {s_in, EXP_INF, {NMAN{1'b0}}};
      sp_f.inf = 1'b1;
    end else if (zb) begin
      sp_q     = {s_in, EXP_INF, {NMAN{1'b0}}};
      sp_f.inf = 1'b1;
      sp_f.dz  = 1'b1;
    end else if (!(ca.norm & cb.norm)) begin
      sp_q      = {s_in, {(W-1){1'b0}}};
      sp_f.zero = 1'b1;
    end else begin
      sp_div = 1'b1;
    end
  end

  // Normalise, round and pack the iteration result.
  logic                 sign_r;
  logic signed [EW-1:0] diff_r, e_pre, e_fin;
  logic [NMAN-1:0]      frac;
  logic [NMAN:0]        frac_r;
  logic                 g, r, rnd_up, inexact;
  logic [W-1:0]         rn_q;
  fp_flags_t            rn_f;

  always_comb begin
    // Quotient in [0.5, 2): integer bit clear means one extra left shift.
    if (quo[QBITS-1]) begin
      frac = quo[QBITS-2:2];
      g    = quo[1];
      r    = quo[0];
    end else begin
      frac = quo[QBITS-3:1];
      g    = quo[0];
      r    = 1'b0;
    end
    e_pre   = diff_r + E_BIAS - {{(EW-1){1'b0}}, ~quo[QBITS-1]};
    inexact = g | r | rem_nz;
    rnd_up  = (RND_MODE == RNE) ? (g & (r | rem_nz | frac[0])) : 1'b0;
    // Carry-out leaves frac_r[NMAN-1:0] = 0, i.e. mantissa 1.0 at e+1.
    frac_r  = {1'b0, frac} + {{NMAN{1'b0}}, rnd_up};
    e_fin   = e_pre + {{(EW-1){1'b0}}, frac_r[NMAN]};
    rn_q    = '0;
    rn_f    = '0;
    if (e_fin >= E_MAX) begin
      rn_q     = {sign_r, EXP_INF, {NMAN{1'b0}}};
      rn_f.inf = 1'b1;
      rn_f.of  = 1'b1;
      rn_f.nx  = 1'b1;
    end else if (e_fin <= E_ZERO) begin
      rn_q      = {sign_r, {(W-1){1'b0}}};
      rn_f.zero = 1'b1;
      rn_f.uf   = 1'b1;
      rn_f.nx   = 1'b1;
    end else begin
      rn_q      = {sign_r, e_fin[NEXP-1:0], frac_r[NMAN-1:0]};
      rn_f.norm = 1'b1;
      rn_f.nx   = inexact;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept)       state_nx = sp_div ? DIV : DONE;
      DIV:  if (it_done)      state_nx = RND;
      RND:                    state_nx = DONE;
      DONE: if (io.out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    io.in_ready  = (state == IDLE);
    io.out_valid = (state == DONE);
    accept       = (state == IDLE) & io.in_valid;
    start        = accept & sp_div;
  end

  logic [W-1:0] q_r;
  fp_flags_t    f_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r    <= '0;
      f_r    <= '0;
      sign_r <= 1'b0;
      diff_r <= '0;
    end else if (accept) begin
      q_r    <= sp_q;
      f_r    <= sp_f;
      sign_r <= s_in;
      diff_r <= $signed({2'b00, io.a[W-2:NMAN]}) - $signed({2'b00, io.b[W-2:NMAN]});
    end else if (state == RND) begin
      q_r <= rn_q;
      f_r <= rn_f;
    end
  end

  assign io.q    = q_r;
  assign io.nan  = f_r.nan;
  assign io.inf  = f_r.inf;
  assign io.zero = f_r.zero;
  assign io.norm = f_r.norm;
  assign io.dz   = f_r.dz;
  assign io.of   = f_r.of;
  assign io.uf   = f_r.uf;
  assign io.nx   = f_r.nx;

endmodule

// File: tb/tb_fp_div_seq.sv
// tb/tb_fp_div_seq.sv - randomized self-checking bench for fp_div_seq (binary32)
module tb_fp_div_seq;

  localparam int NEXP = 8;
  localparam int NMAN = 23;
  localparam int ND   = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fp_div_seq_if #(.NEXP(NEXP), .NMAN(NMAN)) io ();

  fp_div_seq #(.NEXP(NEXP), .NMAN(NMAN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  // flag byte order: nan inf zero norm dz of uf nx
  localparam logic [31:0] DA [ND] = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                                      32'h00000000, 32'h7F800000, 32'h00000000, 32'h7F7FFFFF,
                                      32'h00800000, 32'h00000001};
  localparam logic [31:0] DB [ND] = '{32'h40000000, 32'h40400000, 32'h3F800001, 32'h80000000,
                                      32'h00000000, 32'h7F800000, 32'h40000000, 32'h3F000000,
                                      32'h40000000, 32'h3F800000};
  localparam logic [31:0] DQ [ND] = '{32'h40400000, 32'h3EAAAAAB, 32'h3F7FFFFE, 32'hFF800000,
                                      32'h7FC00000, 32'h7FC00000, 32'h00000000, 32'h7F800000,
                                      32'h00000000, 32'h00000000};
  localparam logic [7:0]  DF [ND] = '{8'h10, 8'h11, 8'h11, 8'h48, 8'h80, 8'h80, 8'h20, 8'h45,
                                      8'h23, 8'h20};
  localparam int          DL [ND] = '{27, 27, 27, 1, 1, 1, 1, 27, 27, 1};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] flags_now();
    return {io.nan, io.inf, io.zero, io.norm, io.dz, io.of, io.uf, io.nx};
  endfunction

  // Reference: exact integer quotient of the significands, then RNE on the
  // discarded bits plus the division remainder.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [7:0] f, output int lat);
    logic [63:0] num, den, quo, rm, mant, lost, half;
    int sh, e;
    logic s, an, bn, ai, bi, az, bz, up, nx;
    s  = a[31] ^ b[31];
    az = (a[30:23] == 8'h00);
    bz = (b[30:23] == 8'h00);
    an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    lat = 1;
    if (an || bn || (az && bz) || (ai && bi)) begin
      q = 32'h7FC00000; f = 8'h80;
    end else if (ai) begin
      q = {s, 8'hFF, 23'd0}; f = 8'h40;
    end else if (bz) begin
      q = {s, 8'hFF, 23'd0}; f = 8'h48;
    end else if (az || bi) begin
      q = {s, 31'd0}; f = 8'h20;
    end else begin
      lat = 27;
      num = {40'd0, 1'b1, a[22:0]} << 40;
      den = {40'd0, 1'b1, b[22:0]};
      quo = num / den;
      rm  = num % den;
      e   = int'(a[30:23]) - int'(b[30:23]) + 127;
      if (quo >= (64'd1 << 40)) sh = 17;
      else begin
        sh = 16;
        e  = e - 1;
      end
      mant = quo >> sh;
      lost = quo & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      nx   = (lost != 0) || (rm != 0);
      up   = (lost > half) || ((lost == half) && ((rm != 0) || mant[0]));
      mant = mant + 64'(up);
      if (mant == (64'd1 << 24)) begin
        mant = 64'd1 << 23;
        e    = e + 1;
      end
      if (e >= 255) begin
        q = {s, 8'hFF, 23'd0}; f = 8'h45;
      end else if (e <= 0) begin
        q = {s, 31'd0}; f = 8'h23;
      end else begin
        q = {s, e[7:0], mant[22:0]}; f = {7'b0001000, nx};
      end
    end
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 15))
      0:       r[30:23] = 8'h00;
      1:       r[30:23] = 8'hFF;
      2:       begin r[30:23] = 8'hFF; r[22:0] = '0; end
      3:       r[30:0] = '0;
      4:       r[22:0] = '0;
      default: ;
    endcase
    return r;
  endfunction

  task automatic wait_result(input string tag, input int exp_lat,
                             input logic [31:0] eq, input logic [7:0] ef);
    int lat;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!io.out_valid && lat < 200);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " q"}, 64'(io.q), 64'(eq));
    check({tag, " flags"}, 64'(flags_now()), 64'(ef));
  endtask

  task automatic drain(input int hold);
    repeat (hold) @(negedge clk);
    @(negedge clk);
    io.out_ready = 1'b1;
    @(posedge clk);
    #1;
    io.out_ready = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input int exp_lat, input logic [31:0] eq, input logic [7:0] ef,
                       input int hold);
    @(negedge clk);
    io.a        = a;
    io.b        = b;
    io.in_valid = 1'b1;
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    io.a        = $urandom;
    io.b        = $urandom;
    wait_result(tag, exp_lat, eq, ef);
    drain(hold);
  endtask

  initial begin
    io.in_valid  = 1'b0;
    io.a         = '0;
    io.b         = '0;
    io.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", 64'(io.in_ready), 64'd1);
    check("reset out_valid", 64'(io.out_valid), 64'd0);
    check("reset q", 64'(io.q), 64'd0);
    check("reset flags", 64'(flags_now()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < ND; i++)
      do_op($sformatf("directed%0d", i), DA[i], DB[i], DL[i], DQ[i], DF[i], 0);

    // Output held under back-pressure; in_valid ignored outside IDLE.
    @(negedge clk);
    io.a        = 32'h40C00000;
    io.b        = 32'h40000000;
    io.in_valid = 1'b1;
    @(posedge clk);
    #1;
    io.a = 32'h3F800000;
    io.b = 32'h40400000;
    wait_result("hs first", 27, 32'h40400000, 8'h10);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("hs hold q", 64'(io.q), 64'h40400000);
      check("hs hold flags", 64'(flags_now()), 64'h10);
      check("hs hold in_ready", 64'(io.in_ready), 64'd0);
      check("hs hold out_valid", 64'(io.out_valid), 64'd1);
    end
    @(negedge clk);
    io.out_ready = 1'b1;
    @(posedge clk);
    #1;
    io.out_ready = 1'b0;
    check("hs back to idle", 64'(io.in_ready), 64'd1);
    check("hs out_valid drop", 64'(io.out_valid), 64'd0);
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    wait_result("hs second", 27, 32'h3EAAAAAB, 8'h11);
    drain(0);

    // Asynchronous reset in the middle of a division.
    @(negedge clk);
    io.a        = 32'h3F800000;
    io.b        = 32'h40400000;
    io.in_valid = 1'b1;
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst in_ready", 64'(io.in_ready), 64'd1);
    check("async rst out_valid", 64'(io.out_valid), 64'd0);
    check("async rst q", 64'(io.q), 64'd0);
    check("async rst flags", 64'(flags_now()), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("post reset", 32'h40C00000, 32'h40000000, 27, 32'h40400000, 8'h10, 0);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra, rb, eq;
      logic [7:0]  ef;
      int          el;
      ra = rand_fp();
      rb = rand_fp();
      model(ra, rb, eq, ef, el);
      do_op($sformatf("rand %08h/%08h", ra, rb), ra, rb, el, eq, ef, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
